// File: rtl/axi_dc_clkdown_ctrl.sv
// axi_dc_clkdown_ctrl: drains outstanding AXI traffic, then clocks down and isolates the port on sleep request; clk_i/rst_i, sleep/incoming/handshake inputs in, clock_down/isolate/ack/wake/timeout/counts out
module axi_dc_clkdown_ctrl #(
  parameter int MAX_OUTST     = 16,
  parameter int GATE_CYCLES   = 2,
  parameter int WAKE_CYCLES   = 2,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter bit WAKE_ON_REQ   = 1'b1,
  localparam int CNT_W        = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sleep_req_i,
  input  logic             incoming_req_i,
  input  logic             aw_hs_i,
  input  logic             ar_hs_i,
  input  logic             b_hs_i,
  input  logic             r_last_hs_i,
  output logic             clock_down_o,
  output logic             isolate_o,
  output logic             sleep_ack_o,
  output logic             wake_evt_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] wr_outst_o,
  output logic [CNT_W-1:0] rd_outst_o
);
  localparam int TMR_W = DRAIN_TIMEOUT > 0 ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  typedef enum logic [2:0] {ACTIVE, DRAIN, GATE, SLEEP, WAKE} state_t;
  state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0] ph_q, ph_d;
  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic mask_q, mask_d, timeout_q, timeout_d, evt_q, evt_d;
  logic cd_q, cd_d, iso_q, iso_d;
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ph_d      = ph_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    evt_d     = 1'b0;
    case (state_q)
      ACTIVE: if (sleep_req_i && !mask_q) begin
        state_d = DRAIN;
        tmr_d   = TMR_W'(1);
      end
      DRAIN: begin
        // timer holds the number of DRAIN cycles spent so far, saturating
        tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
        if (!sleep_req_i) state_d = ACTIVE;
        else if (!incoming_req_i && wr_q == '0 && rd_q == '0) begin
          state_d = GATE;
          ph_d    = 8'd1;
        end else if (!incoming_req_i && DRAIN_TIMEOUT != 0 && tmr_q == TMR_MAX) begin
          state_d   = GATE;
          ph_d      = 8'd1;
          timeout_d = 1'b1;
        end
      end
      GATE: begin
        state_d = !sleep_req_i ? WAKE : (ph_q >= 8'(GATE_CYCLES)) ? SLEEP : GATE;
        ph_d    = !sleep_req_i ? 8'd1 : ph_q + 8'd1;
      end
      SLEEP: if (WAKE_ON_REQ && incoming_req_i) begin
        state_d = WAKE;
        ph_d    = 8'd1;
        evt_d   = 1'b1;
        mask_d  = 1'b1;
      end else if (!sleep_req_i) begin
        state_d = WAKE;
        ph_d    = 8'd1;
      end
      WAKE: begin
        state_d = (ph_q >= 8'(WAKE_CYCLES)) ? ACTIVE : WAKE;
        ph_d    = ph_q + 8'd1;
      end
      default: state_d = ACTIVE;
    endcase
    mask_d = sleep_req_i & mask_d;
    wr_d = (aw_hs_i && !b_hs_i && wr_q != CNT_MAX) ? wr_q + 1'b1 :
           (b_hs_i && !aw_hs_i && wr_q != '0) ? wr_q - 1'b1 : wr_q;
    rd_d = (ar_hs_i && !r_last_hs_i && rd_q != CNT_MAX) ? rd_q + 1'b1 :
           (r_last_hs_i && !ar_hs_i && rd_q != '0) ? rd_q - 1'b1 : rd_q;
    // anything still counted at sleep entry is dropped by the isolated wrapper
    wr_d = (state_d == SLEEP && state_q != SLEEP) ? '0 : wr_d;
    rd_d = (state_d == SLEEP && state_q != SLEEP) ? '0 : rd_d;
    cd_d  = state_d == GATE || state_d == SLEEP || state_d == WAKE;
    iso_d = state_d == SLEEP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ACTIVE;
      tmr_q     <= '0;
      ph_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      mask_q    <= 1'b0;
      timeout_q <= 1'b0;
      evt_q     <= 1'b0;
      cd_q      <= 1'b0;
      iso_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ph_q      <= ph_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      evt_q     <= evt_d;
      cd_q      <= cd_d;
      iso_q     <= iso_d;
    end
  end
  assign clock_down_o = cd_q;
  assign isolate_o    = iso_q;
  assign sleep_ack_o  = iso_q;
  assign wake_evt_o   = evt_q;
  assign timeout_o    = timeout_q;
  assign wr_outst_o   = wr_q;
  assign rd_outst_o   = rd_q;
endmodule

// File: tb/tb_axi_dc_clkdown_ctrl.sv
// tb_axi_dc_clkdown_ctrl: directed and random checks of axi_dc_clkdown_ctrl against a cycle-count reference model
module tb_axi_dc_clkdown_ctrl;
  localparam int MO = 16, GC = 2, WC = 2, TO = 8;
  localparam int MA = 0, MD = 1, MG = 2, MS = 3, MW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic sreq = 1'b0, inc = 1'b0, aw = 1'b0, ar = 1'b0, b = 1'b0, r = 1'b0;
  logic clock_down, isolate, sleep_ack, wake_evt, timeout;
  logic [4:0] wr_outst, rd_outst;
  int tests = 0, fails = 0;
  int m_mode = MA, m_ph = 0, m_wr = 0, m_rd = 0;
  bit m_mask = 0, m_to = 0, m_evt = 0;
  always #5 clk = ~clk;
  axi_dc_clkdown_ctrl #(.MAX_OUTST(MO), .GATE_CYCLES(GC), .WAKE_CYCLES(WC),
    .DRAIN_TIMEOUT(TO), .WAKE_ON_REQ(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .sleep_req_i(sreq), .incoming_req_i(inc),
    .aw_hs_i(aw), .ar_hs_i(ar), .b_hs_i(b), .r_last_hs_i(r),
    .clock_down_o(clock_down), .isolate_o(isolate), .sleep_ack_o(sleep_ack),
    .wake_evt_o(wake_evt), .timeout_o(timeout),
    .wr_outst_o(wr_outst), .rd_outst_o(rd_outst));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int clip(input int v);
    return v < 0 ? 0 : (v > MO ? MO : v);
  endfunction
  // m_ph counts cycles spent in the current mode, 1 on the first cycle
  task automatic model_step();
    int nm;
    bit ev;
    nm = m_mode;
    ev = 0;
    if (rst) begin
      m_mode = MA; m_ph = 0; m_wr = 0; m_rd = 0; m_mask = 0; m_to = 0; m_evt = 0;
      return;
    end
    case (m_mode)
      MA: if (sreq && !m_mask) nm = MD;
      MD: if (!sreq) nm = MA;
          else if (!inc && m_wr == 0 && m_rd == 0) nm = MG;
          else if (!inc && TO != 0 && m_ph >= TO) begin nm = MG; m_to = 1; end
      MG: if (!sreq) nm = MW; else if (m_ph >= GC) nm = MS;
      MS: if (inc) begin nm = MW; ev = 1; m_mask = 1; end else if (!sreq) nm = MW;
      default: if (m_ph >= WC) nm = MA;
    endcase
    if (!sreq) m_mask = 0;
    m_wr = clip(m_wr + int'(aw) - int'(b));
    m_rd = clip(m_rd + int'(ar) - int'(r));
    if (nm == MS && m_mode != MS) begin m_wr = 0; m_rd = 0; end
    m_ph = (nm == m_mode) ? m_ph + 1 : 1;
    m_mode = nm;
    m_evt = ev;
  endtask
  task automatic check_all();
    chk("clock_down", clock_down, (m_mode == MG || m_mode == MS || m_mode == MW));
    chk("isolate", isolate, m_mode == MS);
    chk("sleep_ack", sleep_ack, m_mode == MS);
    chk("wake_evt", wake_evt, m_evt);
    chk("timeout", timeout, m_to);
    chk("wr_outst", wr_outst, m_wr);
    chk("rd_outst", rd_outst, m_rd);
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask
  task automatic hs(input logic a_w, input logic a_r, input logic b_b, input logic r_r);
    aw = a_w; ar = a_r; b = b_b; r = r_r;
    tick();
    aw = 0; ar = 0; b = 0; r = 0;
  endtask
  initial begin
    tick(2);
    chk("rst_state", {clock_down, isolate, sleep_ack, wake_evt, timeout, wr_outst, rd_outst}, 0);
    rst = 0;
    tick();
    // idle sleep with fixed cycle positions
    sreq = 1;
    tick();
    chk("idle_drain_cd", clock_down, 0);
    tick();
    chk("idle_gate_cd", clock_down, 1);
    chk("idle_gate_iso", isolate, 0);
    tick();
    chk("idle_gate3_iso", isolate, 0);
    tick();
    chk("idle_sleep_iso", isolate, 1);
    chk("idle_sleep_ack", sleep_ack, 1);
    tick(6);
    sreq = 0;
    tick();
    chk("idle_wake_iso", isolate, 0);
    chk("idle_wake_cd", clock_down, 1);
    tick();
    chk("idle_wake2_cd", clock_down, 1);
    tick();
    chk("idle_active_cd", clock_down, 0);
    // drain with traffic, then abort in GATE
    repeat (3) hs(1, 0, 0, 0);
    repeat (2) hs(0, 1, 0, 0);
    chk("traffic_wr", wr_outst, 3);
    chk("traffic_rd", rd_outst, 2);
    sreq = 1;
    tick();
    repeat (3) hs(0, 0, 1, 0);
    chk("drain_hold_cd", clock_down, 0);
    repeat (2) hs(0, 0, 0, 1);
    chk("drain_hold2_cd", clock_down, 0);
    tick();
    chk("drain_gate_cd", clock_down, 1);
    sreq = 0;
    tick();
    chk("abort_iso", isolate, 0);
    chk("abort_cd", clock_down, 1);
    tick(2);
    chk("abort_active_cd", clock_down, 0);
    // drain timeout with one write never answered
    hs(1, 0, 0, 0);
    sreq = 1;
    tick(8);
    chk("to_drain_cd", clock_down, 0);
    tick();
    chk("to_gate_cd", clock_down, 1);
    chk("to_flag", timeout, 1);
    chk("to_wr_held", wr_outst, 1);
    tick(2);
    chk("to_sleep_iso", isolate, 1);
    chk("to_sleep_wr", wr_outst, 0);
    // request wake while sleep_req stays high
    inc = 1;
    tick();
    inc = 0;
    chk("reqwake_evt", wake_evt, 1);
    chk("reqwake_iso", isolate, 0);
    tick();
    chk("reqwake_evt_pulse", wake_evt, 0);
    tick();
    chk("reqwake_active_cd", clock_down, 0);
    tick(4);
    chk("mask_holds_cd", clock_down, 0);
    chk("to_sticky", timeout, 1);
    sreq = 0;
    tick();
    sreq = 1;
    tick(2);
    chk("mask_cleared_gate", clock_down, 1);
    sreq = 0;
    tick(3);
    // counter boundaries
    hs(1, 1, 0, 0);
    hs(1, 1, 1, 1);
    chk("simul_wr", wr_outst, 1);
    chk("simul_rd", rd_outst, 1);
    hs(0, 0, 1, 1);
    hs(0, 0, 1, 1);
    chk("underflow_wr", wr_outst, 0);
    chk("underflow_rd", rd_outst, 0);
    repeat (17) hs(1, 1, 0, 0);
    chk("sat_wr", wr_outst, 16);
    chk("sat_rd", rd_outst, 16);
    repeat (16) hs(0, 0, 1, 1);
    // reset while asleep
    sreq = 1;
    tick(4);
    chk("pre_rst_iso", isolate, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_sleep", {clock_down, isolate, sleep_ack, wake_evt, timeout, wr_outst, rd_outst}, 0);
    sreq = 0;
    tick();
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) sreq = ~sreq;
      inc = $urandom_range(19) == 0;
      aw = $urandom_range(2) == 0;
      ar = $urandom_range(2) == 0;
      b = $urandom_range(2) == 0;
      r = $urandom_range(2) == 0;
      rst = $urandom_range(499) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
